fm_ycbcr_ctrl: RTL

//  Sequencer around the csc_top RGB->YCbCr datapath in the HDMI output path. Accepts pixels from the

---
 rtl/fm_ycbcr_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/fm_ycbcr_ctrl.sv
// Pixel sequencer around csc_top: stage0 capture, sync/RGB delay line matched to the CSC, RGB/444/422 output formatting.
// Optional colour-bar source enabled by defining FM_YCBCR_CTRL_PATTERN_EN.
module fm_ycbcr_ctrl #(
    parameter int CSC_LAT   = 3,
    parameter int UF_W      = 16,
    parameter int BAR_SHIFT = 7
) (
    input  logic            clk_v,
    input  logic            rst,
    input  logic [1:0]      i_cfg_mode,
    input  logic            i_cfg_wr,
    input  logic            i_cfg_pat,
    input  logic            i_uf_clr,
    input  logic            i_de,
    input  logic            i_hsync,
    input  logic            i_vsync,
    input  logic            i_pix_valid,
    input  logic [7:0]      i_r,
    input  logic [7:0]      i_g,
    input  logic [7:0]      i_b,
    output logic            o_pix_ack,
    output logic [7:0]      o_csc_r,
    output logic [7:0]      o_csc_g,
    output logic [7:0]      o_csc_b,
    input  logic [7:0]      i_csc_y,
    input  logic [7:0]      i_csc_cb,
    input  logic [7:0]      i_csc_cr,
    output logic            o_de,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic [7:0]      o_d0,
    output logic [7:0]      o_d1,
    output logic [7:0]      o_d2,
    output logic [UF_W-1:0] o_uf_cnt,
    output logic [1:0]      o_mode
);
    localparam int DW = 27;
    localparam logic [1:0] MODE_RGB = 2'd0;
    localparam logic [1:0] MODE_444 = 2'd1;
    localparam logic [1:0] MODE_422 = 2'd2;

    logic            de0_q, de0_d, hs0_q, hs0_d, vs0_q, vs0_d;
    logic [23:0]     pix0_q, pix0_d;
    logic [DW-1:0]   dl_q [CSC_LAT];
    logic [DW-1:0]   dl_d [CSC_LAT];
    logic [1:0]      mode_q, mode_d, pend_q, pend_d;
    logic            phase_q, phase_d;
    logic [UF_W-1:0] uf_q, uf_d;
    logic            de_out_q, de_out_d, hs_out_q, hs_out_d, vs_out_q, vs_out_d;
    logic [7:0]      d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic            pat_on;
    logic [23:0]     bar_rgb;
    logic            tap_de, tap_hs, tap_vs;
    logic [23:0]     tap_pix;

`ifdef FM_YCBCR_CTRL_PATTERN_EN
    logic [11:0] x_q, x_d;
    logic [2:0]  bar_idx;

    assign pat_on  = i_cfg_pat;
    assign bar_idx = x_q[BAR_SHIFT+2:BAR_SHIFT];

    always_comb begin
        x_d = i_de ? x_q + 12'd1 : 12'd0;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_ff @(posedge clk_v) begin
        if (rst) begin
            x_q <= '0;
        end else begin
            x_q <= x_d;
        end
    end
`else
    // Pattern source not built: the enable is deliberately masked off.
    assign pat_on  = i_cfg_pat & 1'b0;
    assign bar_rgb = '0;
`endif

    assign o_pix_ack = i_de & i_pix_valid & ~pat_on & ~rst;
    assign {tap_de, tap_hs, tap_vs, tap_pix} = dl_q[CSC_LAT-1];

    always_comb begin
        de0_d = i_de;
        hs0_d = i_hsync;
        vs0_d = i_vsync;
        if (!i_de) begin
            pix0_d = '0;
        end else if (pat_on) begin
            pix0_d = bar_rgb;
        end else if (i_pix_valid) begin
            pix0_d = {i_r, i_g, i_b};
        end else begin
            pix0_d = '0;
        end

        uf_d = uf_q;
        if (i_uf_clr) begin
            uf_d = '0;
        end else if (i_de && !i_pix_valid && !pat_on && !(&uf_q)) begin
            uf_d = uf_q + 1'b1;
        end

        // Mode 3 is stored as 1; a write coinciding with the vsync edge goes live directly.
        pend_d = pend_q;
        if (i_cfg_wr) begin
            pend_d = (i_cfg_mode == 2'd3) ? MODE_444 : i_cfg_mode;
        end
        mode_d = (i_vsync && !vs0_q) ? pend_d : mode_q;

        dl_d[0] = {de0_q, hs0_q, vs0_q, pix0_q};
        for (int i = 1; i < CSC_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    always_comb begin
        phase_d  = tap_de ? ~phase_q : 1'b0;
        de_out_d = tap_de;
        hs_out_d = tap_hs;
        vs_out_d = tap_vs;
        d0_d     = 8'h00;
        d1_d     = 8'h00;
        d2_d     = 8'h00;
        if (tap_de) begin
            case (mode_q)
                MODE_RGB: begin
                    d0_d = tap_pix[23:16];
                    d1_d = tap_pix[15:8];
                    d2_d = tap_pix[7:0];
                end
                MODE_422: begin
                    d0_d = i_csc_y;
                    d1_d = phase_q ? i_csc_cr : i_csc_cb;
                    d2_d = 8'h00;
                end
                default: begin
                    d0_d = i_csc_y;
                    d1_d = i_csc_cb;
                    d2_d = i_csc_cr;
                end
            endcase
        end else begin
            case (mode_q)
                MODE_RGB: begin
                    d0_d = 8'h00;
                    d1_d = 8'h00;
                    d2_d = 8'h00;
                end
                MODE_422: begin
                    d0_d = 8'h10;
                    d1_d = 8'h80;
                    d2_d = 8'h00;
                end
                default: begin
                    d0_d = 8'h10;
                    d1_d = 8'h80;
                    d2_d = 8'h80;
                end
            endcase
        end
    end

    always_ff @(posedge clk_v) begin
        if (rst) begin
            de0_q    <= 1'b0;
            hs0_q    <= 1'b0;
            vs0_q    <= 1'b0;
            pix0_q   <= '0;
            for (int i = 0; i < CSC_LAT; i++) begin
                dl_q[i] <= '0;
            end
            mode_q   <= MODE_444;
            pend_q   <= MODE_444;
            phase_q  <= 1'b0;
            uf_q     <= '0;
            de_out_q <= 1'b0;
            hs_out_q <= 1'b0;
            vs_out_q <= 1'b0;
            d0_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
        end else begin
            de0_q    <= de0_d;
            hs0_q    <= hs0_d;
            vs0_q    <= vs0_d;
            pix0_q   <= pix0_d;
            for (int i = 0; i < CSC_LAT; i++) begin
                dl_q[i] <= dl_d[i];
            end
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            phase_q  <= phase_d;
            uf_q     <= uf_d;
            de_out_q <= de_out_d;
            hs_out_q <= hs_out_d;
            vs_out_q <= vs_out_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
        end
    end

    assign o_csc_r  = pix0_q[23:16];
    assign o_csc_g  = pix0_q[15:8];
    assign o_csc_b  = pix0_q[7:0];
    assign o_de     = de_out_q;
    assign o_hsync  = hs_out_q;
    assign o_vsync  = vs_out_q;
    assign o_d0     = d0_q;
    assign o_d1     = d1_q;
    assign o_d2     = d2_q;
    assign o_uf_cnt = uf_q;
    assign o_mode   = mode_q;
endmodule
